// File: rtl/fast_inverse_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : fast_inverse_sqrt
// Brief    : 4-stage pipelined binary32 1/sqrt(x): bit-trick seed + one
//            Newton-Raphson step, special operands bypass the arithmetic.
// Revision : 1.0
// ============================================================================
module fast_inverse_sqrt #(
  parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] x,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam int          LATENCY      = 4;
  localparam logic [31:0] QNAN         = 32'h7FC00000;
  localparam logic [31:0] POS_INF      = 32'h7F800000;
  localparam logic [31:0] NEG_INF      = 32'hFF800000;
  // 1.5 in a fixed-point format with 54 fractional bits
  localparam logic [55:0] THREE_HALVES = 56'h60000000000000;

  // n[55] must be set; returns {exponent carry, rounded 1.23 mantissa}
  function automatic logic [24:0] round56(input logic [55:0] n);
    logic [24:0] m;
    m = {1'b0, n[55:32]} + {24'd0, n[31] & ((|n[30:0]) | n[32])};
    if (m[24]) return {1'b1, 24'h800000};
    return {1'b0, m[23:0]};
  endfunction

  // left-justify a [1,4) mantissa product; the caller adds p[47] to the exponent
  function automatic logic [55:0] align48(input logic [47:0] p);
    return p[47] ? {p, 8'd0} : {p[46:0], 9'd0};
  endfunction

  logic [LATENCY-1:0] vld_q, vld_d;
  logic               s1_spec_q, s1_spec_d, s2_spec_q, s2_spec_d, s3_spec_q, s3_spec_d;
  logic [31:0]        s1_sval_q, s1_sval_d, s2_sval_q, s2_sval_d, s3_sval_q, s3_sval_d;
  logic [23:0]        s1_mx_q, s1_mx_d, s2_mx_q, s2_mx_d;
  logic [7:0]         s1_ex_q, s1_ex_d, s2_ex_q, s2_ex_d;
  logic [23:0]        s1_my_q, s1_my_d, s2_my_q, s2_my_d, s3_my_q, s3_my_d;
  logic [7:0]         s1_ey_q, s1_ey_d, s2_ey_q, s2_ey_d, s3_ey_q, s3_ey_d;
  logic [23:0]        s2_sqm_q, s2_sqm_d, s3_hm_q, s3_hm_d;
  logic signed [9:0]  s2_sqe_q, s2_sqe_d, s3_he_q, s3_he_d;
  logic [31:0]        result_q, result_d;

  logic [31:0]        seed;
  logic [47:0]        sq_p, t_p, y_p;
  logic [24:0]        sq_r, t_r, h_r, y_r;
  logic signed [9:0]  ey_u, ex_u, e_p, e_y;
  logic [9:0]         t_sh;
  logic [55:0]        t_fix, h_fix;
  logic [5:0]         h_lead;
  logic               unused_bits;

  assign unused_bits = ^{seed[31], e_y[9:8], y_r[23]};

  // Stage 1: classify and seed
  always_comb begin
    vld_d     = {vld_q[LATENCY-2:0], in_valid};
    seed      = MAGIC - {1'b0, x[31:1]};
    s1_spec_d = 1'b1;
    s1_sval_d = QNAN;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) s1_sval_d = QNAN;
    else if (x[30:23] == 8'd0)                 s1_sval_d = x[31] ? NEG_INF : POS_INF;
    else if (x[31])                            s1_sval_d = QNAN;
    else if (x[30:23] == 8'hFF)                s1_sval_d = 32'h0;
    else                                       s1_spec_d = 1'b0;
    s1_mx_d = {1'b1, x[22:0]};
    s1_ex_d = x[30:23];
    s1_my_d = {1'b1, seed[22:0]};
    s1_ey_d = seed[30:23];
  end

  // Stage 2: y0^2
  always_comb begin
    sq_p      = {24'd0, s1_my_q} * {24'd0, s1_my_q};
    sq_r      = round56(align48(sq_p));
    ey_u      = $signed({2'b00, s1_ey_q}) - 10'sd127;
    s2_sqm_d  = sq_r[23:0];
    s2_sqe_d  = (ey_u <<< 1) + $signed({9'd0, sq_p[47]}) + $signed({9'd0, sq_r[24]});
    s2_spec_d = s1_spec_q;
    s2_sval_d = s1_sval_q;
    s2_mx_d   = s1_mx_q;
    s2_ex_d   = s1_ex_q;
    s2_my_d   = s1_my_q;
    s2_ey_d   = s1_ey_q;
  end

  // Stage 3: h = 1.5 - 0.5*x*y0^2; the halving is the -1 on the exponent
  always_comb begin
    t_p  = {24'd0, s2_sqm_q} * {24'd0, s2_mx_q};
    t_r  = round56(align48(t_p));
    ex_u = $signed({2'b00, s2_ex_q}) - 10'sd127;
    e_p  = s2_sqe_q + ex_u - 10'sd1 + $signed({9'd0, t_p[47]}) + $signed({9'd0, t_r[24]});
    t_sh = -e_p;
    if (e_p > 10'sd0) t_fix = '1;
    else              t_fix = {1'b0, t_r[23:0], 31'd0} >> t_sh;
    h_fix  = (t_fix >= THREE_HALVES) ? 56'd0 : THREE_HALVES - t_fix;
    h_lead = 6'd0;
    for (int i = 0; i < 56; i++) begin
      if (h_fix[i]) h_lead = 6'(i);
    end
    h_r       = round56(h_fix << (6'd55 - h_lead));
    s3_hm_d   = h_r[23:0];
    s3_he_d   = $signed({4'd0, h_lead}) - 10'sd54 + $signed({9'd0, h_r[24]});
    s3_spec_d = s2_spec_q;
    s3_sval_d = s2_sval_q;
    s3_my_d   = s2_my_q;
    s3_ey_d   = s2_ey_q;
  end

  // Stage 4: y1 = y0 * h, result held between valid outputs
  always_comb begin
    y_p      = {24'd0, s3_my_q} * {24'd0, s3_hm_q};
    y_r      = round56(align48(y_p));
    e_y      = $signed({2'b00, s3_ey_q}) + s3_he_q + $signed({9'd0, y_p[47]})
             + $signed({9'd0, y_r[24]});
    result_d = result_q;
    if (vld_q[LATENCY-2])
      result_d = s3_spec_q ? s3_sval_q : {1'b0, e_y[7:0], y_r[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      s1_spec_q <= 1'b0;  s1_sval_q <= '0;  s1_mx_q <= '0;  s1_ex_q <= '0;
      s1_my_q   <= '0;    s1_ey_q   <= '0;
      s2_spec_q <= 1'b0;  s2_sval_q <= '0;  s2_mx_q <= '0;  s2_ex_q <= '0;
      s2_my_q   <= '0;    s2_ey_q   <= '0;  s2_sqm_q <= '0; s2_sqe_q <= '0;
      s3_spec_q <= 1'b0;  s3_sval_q <= '0;  s3_my_q <= '0;  s3_ey_q <= '0;
      s3_hm_q   <= '0;    s3_he_q   <= '0;
      result_q  <= '0;
    end else begin
      vld_q     <= vld_d;
      s1_spec_q <= s1_spec_d; s1_sval_q <= s1_sval_d; s1_mx_q <= s1_mx_d; s1_ex_q <= s1_ex_d;
      s1_my_q   <= s1_my_d;   s1_ey_q   <= s1_ey_d;
      s2_spec_q <= s2_spec_d; s2_sval_q <= s2_sval_d; s2_mx_q <= s2_mx_d; s2_ex_q <= s2_ex_d;
      s2_my_q   <= s2_my_d;   s2_ey_q   <= s2_ey_d;   s2_sqm_q <= s2_sqm_d; s2_sqe_q <= s2_sqe_d;
      s3_spec_q <= s3_spec_d; s3_sval_q <= s3_sval_d; s3_my_q <= s3_my_d; s3_ey_q <= s3_ey_d;
      s3_hm_q   <= s3_hm_d;   s3_he_q   <= s3_he_d;
      result_q  <= result_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_fast_inverse_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : tb_fast_inverse_sqrt
// Brief    : Directed self-checking bench for fast_inverse_sqrt.
// Revision : 1.0
// ============================================================================
module tb_fast_inverse_sqrt;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x;
  logic        out_valid;
  logic [31:0] result;

  int vectors;
  int miscompares;

  fast_inverse_sqrt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .out_valid(out_valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    if (b[31]) m = -m;
    return m * (2.0 ** real'(int'(b[30:23]) - 127));
  endfunction

  function automatic real rel_err(input logic [31:0] r, input logic [31:0] xin);
    real ref_v;
    real d;
    ref_v = 1.0 / $sqrt(f2r(xin));
    d     = f2r(r) - ref_v;
    if (d < 0.0) d = -d;
    return d / ref_v;
  endfunction

  function automatic bit is_pos_normal(input logic [31:0] r);
    return (r[31] == 1'b0) && (r[30:23] != 8'h00) && (r[30:23] != 8'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; x = 32'h0;
    repeat (2) tick();
    vectors++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_init: got valid=%b result=%h want valid=0 result=00000000", out_valid, result);
    end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; x = 32'h40800000;
    repeat (6) tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prefill: got valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: got valid=%b result=%h want valid=0 result=00000000", out_valid, result);
    end
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale c=%0d: got valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; x = 32'h40800000;
    for (int c = 1; c <= 6; c++) begin
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== (c == 4)) begin
        miscompares++;
        $display("FAIL latency c=%0d: got valid=%b want %b", c, out_valid, (c == 4));
      end
      if (c == 4 || c == 5) begin
        vectors++;
        if (result[30:23] !== 8'h7D || rel_err(result, 32'h40800000) > 0.002) begin
          miscompares++;
          $display("FAIL latency_value c=%0d: got %h (%g) want ~0.5 exp 7d", c, result, f2r(result));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [3];
    vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h3E800000;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3);
      x        = (c < 3) ? vec[c] : 32'h0;
      tick();
      vectors++;
      if (c >= 3 && c < 6) begin
        if (out_valid !== 1'b1 || !is_pos_normal(result) || rel_err(result, vec[c-3]) > 0.002) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got valid=%b %h (%g) want ~%g", c - 3, out_valid, result,
                   f2r(result), 1.0 / $sqrt(f2r(vec[c-3])));
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_idle c=%0d: got valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] vin  [8];
    logic [31:0] vexp [8];
    vin[0] = 32'h00000000; vexp[0] = 32'h7F800000;
    vin[1] = 32'h80000000; vexp[1] = 32'hFF800000;
    vin[2] = 32'h00000001; vexp[2] = 32'h7F800000;
    vin[3] = 32'h7F800000; vexp[3] = 32'h00000000;
    vin[4] = 32'h7FC00001; vexp[4] = 32'h7FC00000;
    vin[5] = 32'hBF800000; vexp[5] = 32'h7FC00000;
    vin[6] = 32'hFF800000; vexp[6] = 32'h7FC00000;
    vin[7] = 32'h807FFFFF; vexp[7] = 32'hFF800000;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 8);
      x        = (c < 8) ? vin[c] : 32'h0;
      tick();
      vectors++;
      if (c >= 3 && c < 11) begin
        if (out_valid !== 1'b1 || result !== vexp[c-3]) begin
          miscompares++;
          $display("FAIL special x=%h: got valid=%b %h want %h", vin[c-3], out_valid, result, vexp[c-3]);
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL special_idle c=%0d: got valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] vec [3];
    vec[0] = 32'h00800000; vec[1] = 32'h7F7FFFFF; vec[2] = 32'h3F800001;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3);
      x        = (c < 3) ? vec[c] : 32'h0;
      tick();
      if (c >= 3 && c < 6) begin
        vectors++;
        if (out_valid !== 1'b1 || !is_pos_normal(result) || rel_err(result, vec[c-3]) > 0.002) begin
          miscompares++;
          $display("FAIL extreme x=%h: got valid=%b %h (%g) want ~%g", vec[c-3], out_valid, result,
                   f2r(result), 1.0 / $sqrt(f2r(vec[c-3])));
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ins  [$];
    logic [31:0] expq [$];
    logic [22:0] mants [4];
    logic [3:0]  mv;
    logic [31:0] xe;
    int          i, cyc, sent, got;
    bit          v;
    mants[0] = 23'h000000; mants[1] = 23'h7FFFFF; mants[2] = 23'h2AAAAA; mants[3] = 23'h555555;
    for (int e = 1; e < 255; e++)
      for (int k = 0; k < 4; k++) ins.push_back({1'b0, 8'(e), mants[k]});
    mv = 4'b0; i = 0; cyc = 0; sent = 0; got = 0;
    while (i < ins.size() || mv != 4'b0) begin
      v        = (i < ins.size()) && (cyc % 5 != 2);
      in_valid = v;
      x        = v ? ins[i] : 32'h0;
      if (v) begin
        expq.push_back(ins[i]);
        i++;
        sent++;
      end
      tick();
      mv = {mv[2:0], v};
      if (out_valid !== mv[3]) begin
        vectors++;
        miscompares++;
        $display("FAIL sweep_valid cyc=%0d: got %b want %b", cyc, out_valid, mv[3]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        got++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL sweep_extra cyc=%0d: got %h want no output", cyc, result);
        end else begin
          xe = expq.pop_front();
          if (!is_pos_normal(result) || rel_err(result, xe) > 0.002) begin
            miscompares++;
            $display("FAIL sweep x=%h: got %h (%g) want ~%g", xe, result, f2r(result),
                     1.0 / $sqrt(f2r(xe)));
          end
        end
      end
      cyc++;
      if (cyc > 20000) begin
        vectors++;
        miscompares++;
        $display("FAIL sweep_timeout: got %0d outputs want %0d", got, sent);
        break;
      end
    end
    in_valid = 1'b0;
    repeat (6) tick();
    vectors++;
    if (got != sent || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_count: got %0d outputs want %0d", got, sent);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; x = 32'h0;
    vectors = 0; miscompares = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_special();
    test_extremes();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
